// File: rtl/wisc_pkg.sv
// Shared WISC-F24 decode definitions: opcodes, field encodings, control bundle.
package wisc_pkg;

    // 5-bit opcodes
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_ROT   = 5'b11010;
    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // funct codes of the 11011 R-type group
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_ANDN = 2'b11;

    // write-back data select
    localparam logic [1:0] WB_PC2  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_ALU  = 2'b10;
    localparam logic [1:0] WB_IMM8 = 2'b11;

    // ALU B operand source
    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_ZERO = 2'b11;

    // branch condition
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_C    = 3'b001;
    localparam logic [2:0] BR_Z    = 3'b010;
    localparam logic [2:0] BR_NN   = 3'b011;
    localparam logic [2:0] BR_N    = 3'b100;
    localparam logic [2:0] BR_NZ   = 3'b101;
    localparam logic [2:0] BR_JMP  = 3'b111;

    typedef struct packed {
        logic       regWrt;
        logic       memWrt;
        logic [2:0] brchSig;
        logic       Cin;
        logic       invA;
        logic       invB;
        logic [1:0] wbDataSel;
        logic       stuSel;
        logic       immSrc;
        logic       SLBIsel;
        logic [1:0] BSrc;
        logic       zeroSel;
        logic       jalSel;
        logic       aluJmp;
        logic       sOpSel;
        logic       createDump;
    } ctrl_t;

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERR} state_t;

    // where the destination register index comes from
    typedef enum logic [1:0] {WR_I, WR_R, WR_HI, WR_LINK} wr_src_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational WISC-F24 instruction decoder.
module ctrl_decode_comb
    import wisc_pkg::*;
#(
    parameter int INSTR_W   = 16,
    parameter int REG_IDX_W = 3,
    parameter bit EN_SIIC   = 1'b1
) (
    input  logic [INSTR_W-1:0]   instr,
    output ctrl_t                ctrl,
    output logic [REG_IDX_W-1:0] wr_idx,
    output logic                 exc,
    output logic                 rti,
    output logic                 illegal
);

    logic [4:0] op;
    logic [1:0] funct;
    wr_src_t    wsrc;

    assign op    = instr[INSTR_W-1 -: 5];
    assign funct = instr[1:0];

    // opcode to control bundle; anything not listed decodes as a NOP
    always_comb begin
        ctrl    = '0;
        exc     = 1'b0;
        rti     = 1'b0;
        illegal = 1'b0;
        wsrc    = WR_I;
        case (op)
            OP_HALT: ctrl.createDump = 1'b1;
            OP_SIIC: if (EN_SIIC) exc = 1'b1; else illegal = 1'b1;
            OP_RTI:  if (EN_SIIC) rti = 1'b1; else illegal = 1'b1;
            OP_J: begin
                ctrl.brchSig = BR_JMP;
                ctrl.immSrc  = 1'b1;
            end
            OP_JR: begin
                ctrl.brchSig = BR_JMP;
                ctrl.aluJmp  = 1'b1;
                ctrl.BSrc    = B_IMM;
            end
            OP_JAL: begin
                ctrl.brchSig   = BR_JMP;
                ctrl.immSrc    = 1'b1;
                ctrl.jalSel    = 1'b1;
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_PC2;
                wsrc           = WR_LINK;
            end
            OP_JALR: begin
                ctrl.brchSig   = BR_JMP;
                ctrl.aluJmp    = 1'b1;
                ctrl.BSrc      = B_IMM;
                ctrl.jalSel    = 1'b1;
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_PC2;
                wsrc           = WR_LINK;
            end
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_ALU;
                ctrl.BSrc      = B_IMM;
                // SUBI computes imm - Rs; XORI/ANDNI zero-extend their immediate
                ctrl.Cin       = (op == OP_SUBI);
                ctrl.invA      = (op == OP_SUBI);
                ctrl.invB      = (op == OP_ANDNI);
                ctrl.zeroSel   = (op == OP_XORI) || (op == OP_ANDNI);
            end
            OP_BEQZ: begin ctrl.brchSig = BR_Z;  ctrl.BSrc = B_ZERO; end
            OP_BNEZ: begin ctrl.brchSig = BR_NZ; ctrl.BSrc = B_ZERO; end
            OP_BLTZ: begin ctrl.brchSig = BR_N;  ctrl.BSrc = B_ZERO; end
            OP_BGEZ: begin ctrl.brchSig = BR_NN; ctrl.BSrc = B_ZERO; end
            OP_ST: begin
                ctrl.memWrt = 1'b1;
                ctrl.BSrc   = B_IMM;
            end
            OP_LD: begin
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_MEM;
                ctrl.BSrc      = B_IMM;
            end
            OP_SLBI: begin
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_ALU;
                ctrl.SLBIsel   = 1'b1;
                ctrl.BSrc      = B_IMM;
                ctrl.zeroSel   = 1'b1;
                wsrc           = WR_HI;
            end
            OP_STU: begin
                ctrl.memWrt    = 1'b1;
                ctrl.regWrt    = 1'b1;
                ctrl.stuSel    = 1'b1;
                ctrl.wbDataSel = WB_ALU;
                ctrl.BSrc      = B_IMM;
            end
            OP_LBI: begin
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_IMM8;
                wsrc           = WR_HI;
            end
            OP_BTR, OP_ROT, OP_ALU: begin
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_ALU;
                ctrl.BSrc      = B_REG;
                wsrc           = WR_R;
                if (op == OP_ALU) begin
                    ctrl.Cin  = (funct == FN_SUB);
                    ctrl.invA = (funct == FN_SUB);
                    ctrl.invB = (funct == FN_ANDN);
                end
            end
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                ctrl.regWrt    = 1'b1;
                ctrl.wbDataSel = WB_ALU;
                ctrl.sOpSel    = 1'b1;
                wsrc           = WR_R;
                // compares are Rs - Rt; SCO only needs the carry of Rs + Rt
                ctrl.Cin       = (op != OP_SCO);
                ctrl.invB      = (op != OP_SCO);
            end
            default: ;
        endcase
    end

    // destination index; only register-writing opcodes name one
    always_comb begin
        wr_idx = '0;
        if (ctrl.regWrt) begin
            case (wsrc)
                WR_I:    wr_idx = REG_IDX_W'(instr[7:5]);
                WR_R:    wr_idx = REG_IDX_W'(instr[4:2]);
                WR_HI:   wr_idx = REG_IDX_W'(instr[10:8]);
                WR_LINK: wr_idx = '1;
                default: wr_idx = '0;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage: valid/ready output register plus RUN/HALTED/ERR sequencing.
//
// Handshake: a word moves on any cycle where valid && ready are both high;
// the producer holds its data stable while valid && !ready, and ready never
// depends on the same-cycle valid of the other side.
module ctrl_decode_pipe
    import wisc_pkg::*;
#(
    parameter int INSTR_W   = 16,
    parameter int REG_IDX_W = 3,
    parameter bit EN_SIIC   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output ctrl_t                ctrl,
    output logic [REG_IDX_W-1:0] wr_idx,
    output logic                 exc,
    output logic                 rti,
    output logic                 halted,
    output logic                 err
);

    ctrl_t                d_ctrl;
    logic [REG_IDX_W-1:0] d_wr_idx;
    logic                 d_exc;
    logic                 d_rti;
    logic                 d_illegal;
    logic                 take;
    state_t               state;
    state_t               state_next;

    ctrl_decode_comb #(
        .INSTR_W  (INSTR_W),
        .REG_IDX_W(REG_IDX_W),
        .EN_SIIC  (EN_SIIC)
    ) u_decode (
        .instr  (instr),
        .ctrl   (d_ctrl),
        .wr_idx (d_wr_idx),
        .exc    (d_exc),
        .rti    (d_rti),
        .illegal(d_illegal)
    );

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    // a flush in the same cycle squashes the incoming instruction
    assign take     = in_valid && in_ready && !flush;
    assign halted   = (state == ST_HALTED);
    assign err      = (state == ST_ERR);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // next state: flush releases HALTED, accepted HALT/illegal op leaves RUN
    always_comb begin
        state_next = state;
        if (flush) begin
            if (state == ST_HALTED) state_next = ST_RUN;
        end else if (take) begin
            if (d_illegal)                state_next = ST_ERR;
            else if (d_ctrl.createDump)   state_next = ST_HALTED;
        end
    end

    // output register: load on accept, drop on flush or consumer take
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl      <= '0;
            wr_idx    <= '0;
            exc       <= 1'b0;
            rti       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            ctrl      <= d_ctrl;
            wr_idx    <= d_wr_idx;
            exc       <= d_exc;
            rti       <= d_rti;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios plus random traffic against an ISA-level model.
module tb_ctrl_decode_pipe;
    import wisc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (siic/rti legal)
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] instr;
    ctrl_t       ctrl;
    logic [2:0]  wr_idx;
    logic        exc, rti, halted, err;

    // second DUT with siic/rti illegal
    logic        ns_valid, ns_in_ready, ns_flush, ns_out_valid, ns_ready;
    logic [15:0] ns_instr;
    ctrl_t       ns_ctrl;
    logic [2:0]  ns_wr_idx;
    logic        ns_exc, ns_rti, ns_halted, ns_err;

    ctrl_decode_pipe #(.INSTR_W(16), .REG_IDX_W(3), .EN_SIIC(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl),
        .wr_idx(wr_idx), .exc(exc), .rti(rti), .halted(halted), .err(err)
    );

    ctrl_decode_pipe #(.INSTR_W(16), .REG_IDX_W(3), .EN_SIIC(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(ns_valid), .in_ready(ns_in_ready), .instr(ns_instr),
        .flush(ns_flush), .out_valid(ns_out_valid), .out_ready(ns_ready), .ctrl(ns_ctrl),
        .wr_idx(ns_wr_idx), .exc(ns_exc), .rti(ns_rti), .halted(ns_halted), .err(ns_err)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];
    bit          m_valid;
    bit          m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model (ISA classes) ----------------
    function automatic logic [31:0] ref_bundle(input logic [15:0] ins, input bit en);
        logic [4:0] op;
        logic [1:0] fn;
        ctrl_t      c;
        logic [2:0] wr;
        logic       e, r;
        bit alu_imm, sh_imm, rfmt, setop, branch, jump, link, is_sub, is_andn;
        op = ins[15:11];
        fn = ins[1:0];
        c = '0; wr = 3'd0; e = 1'b0; r = 1'b0;
        alu_imm = op inside {[OP_ADDI:OP_ANDNI]};
        sh_imm  = op inside {[OP_ROLI:OP_SRLI]};
        setop   = op inside {[OP_SEQ:OP_SCO]};
        rfmt    = setop || (op inside {OP_BTR, OP_ROT, OP_ALU});
        branch  = op inside {[OP_BEQZ:OP_BGEZ]};
        jump    = op inside {[OP_J:OP_JALR]};
        link    = op inside {OP_JAL, OP_JALR};
        is_sub  = (op == OP_SUBI) || (op == OP_ALU && fn == 2'b01);
        is_andn = (op == OP_ANDNI) || (op == OP_ALU && fn == 2'b11);
        if (op == OP_SIIC || op == OP_RTI) begin
            // legal: flag only; illegal: everything zero
            e = en && (op == OP_SIIC);
            r = en && (op == OP_RTI);
        end else begin
            c.regWrt = alu_imm || sh_imm || rfmt || link || (op inside {OP_LD, OP_SLBI, OP_STU, OP_LBI});
            c.memWrt = op inside {OP_ST, OP_STU};
            if (jump) c.brchSig = 3'b111;
            else if (op == OP_BEQZ) c.brchSig = 3'b010;
            else if (op == OP_BNEZ) c.brchSig = 3'b101;
            else if (op == OP_BLTZ) c.brchSig = 3'b100;
            else if (op == OP_BGEZ) c.brchSig = 3'b011;
            c.Cin  = is_sub || (op inside {OP_SEQ, OP_SLT, OP_SLE});
            c.invA = is_sub;
            c.invB = is_andn || (op inside {OP_SEQ, OP_SLT, OP_SLE});
            if (link) c.wbDataSel = 2'b00;
            else if (op == OP_LD) c.wbDataSel = 2'b01;
            else if (op == OP_LBI) c.wbDataSel = 2'b11;
            else if (c.regWrt) c.wbDataSel = 2'b10;
            c.stuSel  = (op == OP_STU);
            c.immSrc  = op inside {OP_J, OP_JAL};
            c.SLBIsel = (op == OP_SLBI);
            if (alu_imm || sh_imm || (op inside {OP_JR, OP_JALR, OP_ST, OP_LD, OP_SLBI, OP_STU}))
                c.BSrc = 2'b01;
            else if (branch)
                c.BSrc = 2'b11;
            c.zeroSel    = op inside {OP_XORI, OP_ANDNI, OP_SLBI};
            c.jalSel     = link;
            c.aluJmp     = op inside {OP_JR, OP_JALR};
            c.sOpSel     = setop;
            c.createDump = (op == OP_HALT);
            if (!c.regWrt)                   wr = 3'd0;
            else if (link)                   wr = 3'd7;
            else if (op inside {OP_SLBI, OP_LBI}) wr = ins[10:8];
            else if (rfmt)                   wr = ins[4:2];
            else                             wr = ins[7:5];
        end
        return 32'({c, wr, e, r});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid = 0; instr = '0; flush = 0; out_ready = 0;
        ns_valid = 0; ns_instr = '0; ns_flush = 0; ns_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 0; m_halted = 0;
        exp_q.delete();
    endtask

    // one clock of the main DUT, checked against the model
    task automatic cycle(input logic v, input logic [15:0] ins, input logic fl, input logic rdy);
        bit exp_rdy, acc;
        in_valid = v; instr = ins; flush = fl; out_ready = rdy;
        #1;
        exp_rdy = !m_halted && (!m_valid || rdy);
        acc     = v && exp_rdy && !fl;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_halted = 0; exp_q.delete();
        end else begin
            if (m_valid && rdy) begin
                void'(exp_q.pop_front());
                m_valid = 0;
            end
            if (acc) begin
                exp_q.push_back(ref_bundle(ins, 1'b1));
                m_valid = 1;
                if (ins[15:11] == OP_HALT) m_halted = 1;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid && exp_q.size() > 0)
            check("bundle", 32'({ctrl, wr_idx, exc, rti}), exp_q[0]);
        check("halted", 32'(halted), 32'(m_halted));
        check("err", 32'(err), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_bundle", 32'({ctrl, wr_idx, exc, rti}), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // ADDI
        cycle(1, 16'h4125, 0, 1);
        check("addi_regWrt", 32'(ctrl.regWrt), 1);
        check("addi_wb", 32'(ctrl.wbDataSel), 2);
        check("addi_bsrc", 32'(ctrl.BSrc), 1);
        check("addi_zero", 32'(ctrl.zeroSel), 0);
        check("addi_wr", 32'(wr_idx), 1);

        // ADD then SUB back-to-back
        cycle(1, 16'hD9A8, 0, 1);
        check("add_wr", 32'(wr_idx), 2);
        check("add_cin_inva", 32'({ctrl.Cin, ctrl.invA}), 0);
        cycle(1, 16'hD9A9, 0, 1);
        check("sub_valid", 32'(out_valid), 1);
        check("sub_cin_inva", 32'({ctrl.Cin, ctrl.invA}), 32'b11);
        check("sub_in_ready", 32'(in_ready), 1);

        // JAL held under stall
        cycle(1, 16'h3000, 0, 1);
        repeat (3) cycle(0, 16'h0000, 0, 0);
        check("jal_wr", 32'(wr_idx), 7);
        check("jal_bits", 32'({ctrl.regWrt, ctrl.jalSel, ctrl.immSrc}), 32'b111);
        check("jal_stall_ready", 32'(in_ready), 0);

        // HALT, then flush releases it
        cycle(1, 16'h0000, 0, 1);
        check("halt_dump", 32'(ctrl.createDump), 1);
        check("halt_halted", 32'(halted), 1);
        check("halt_in_ready", 32'(in_ready), 0);
        cycle(0, 16'h4125, 0, 0);
        cycle(0, 16'h0000, 1, 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_halted", 32'(halted), 0);
        check("flush_in_ready", 32'(in_ready), 1);

        // flush together with HALT accept: discarded
        cycle(1, 16'h0000, 1, 1);
        check("flush_halt_state", 32'(halted), 0);

        // flush together with ST: never appears
        cycle(1, 16'h8000, 1, 1);
        check("flush_st_valid", 32'(out_valid), 0);
        cycle(0, 16'h0000, 0, 1);

        // reset in the middle of a stall drops the bundle
        cycle(1, 16'h4125, 0, 0);
        cycle(0, 16'h0000, 0, 0);
        do_reset();
        check("rst_stall_valid", 32'(out_valid), 0);
        check("rst_stall_bundle", 32'({ctrl, wr_idx, exc, rti}), 0);

        // random traffic
        for (int i = 0; i < 700; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if (op == OP_HALT && $urandom_range(0, 3) != 0) op = OP_NOP;
            cycle($urandom_range(0, 3) != 0, {op, 11'($urandom)}, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) != 0);
        end

        // illegal siic with EN_SIIC=0
        do_reset();
        ns_valid = 1; ns_instr = 16'h1000; ns_ready = 1;
        #1;
        check("ns_ready0", 32'(ns_in_ready), 1);
        @(posedge clk); #1;
        ns_valid = 0;
        check("ns_valid", 32'(ns_out_valid), 1);
        check("ns_bundle", 32'({ns_ctrl, ns_wr_idx, ns_exc, ns_rti}), ref_bundle(16'h1000, 1'b0));
        check("ns_err", 32'(ns_err), 1);
        check("ns_in_ready", 32'(ns_in_ready), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("ns_err_sticky", 32'(ns_err), 1);
        end
        ns_flush = 1;
        @(posedge clk); #1;
        ns_flush = 0;
        check("ns_flush_err", 32'(ns_err), 1);
        check("ns_flush_ready", 32'(ns_in_ready), 0);
        ns_valid = 1; ns_instr = 16'h4125;
        @(posedge clk); #1;
        ns_valid = 0;
        check("ns_no_accept", 32'(ns_out_valid), 0);
        do_reset();
        check("ns_rst_err", 32'(ns_err), 0);
        check("ns_rst_ready", 32'(ns_in_ready), 1);

        // illegal rti with EN_SIIC=0
        ns_valid = 1; ns_instr = 16'h1800; ns_ready = 0;
        @(posedge clk); #1;
        ns_valid = 0;
        check("ns_rti_err", 32'(ns_err), 1);
        check("ns_rti_bundle", 32'({ns_ctrl, ns_wr_idx, ns_exc, ns_rti}), 0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
